// File: rtl/pipe_pkg.sv
`default_nettype none
// ==========================================================================
// pipe_pkg : shared EX/MEM field widths, RAM control encodings, payload type
// Revision 1.0
// ==========================================================================
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_RAMC_W = 4;

  // RAM control encodings: {enable, rw, size[1:0]}
  localparam logic [DEF_RAMC_W-1:0] RAMC_NONE     = 4'b0000;
  localparam logic [DEF_RAMC_W-1:0] RAMC_RD_BYTE  = 4'b1000;
  localparam logic [DEF_RAMC_W-1:0] RAMC_RD_WORD  = 4'b1010;
  localparam logic [DEF_RAMC_W-1:0] RAMC_WR_BYTE  = 4'b1100;
  localparam logic [DEF_RAMC_W-1:0] RAMC_WR_WORD  = 4'b1110;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rb;
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_RD_W-1:0]   rd;
    logic [DEF_RAMC_W-1:0] ram_ctrl;
    logic                  l;
    logic                  rf_le;
  } ex_mem_payload_t;

  function automatic int payload_w(input int data_w, input int rd_w, input int ramc_w);
    return 2 * data_w + rd_w + ramc_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ==========================================================================
// pipe_slot : one pipeline storage slot (payload register plus valid bit)
// Revision 1.0
// ==========================================================================
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Clear only drops the valid bit; the payload keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_skid_stage.sv
`default_nettype none
// ==========================================================================
// ex_mem_skid_stage : EX->MEM stage with valid/ready, optional skid entry, flush
// Revision 1.0
// ==========================================================================
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_W    = DEF_RD_W,
  parameter int RAMC_W  = DEF_RAMC_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rb,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [RAMC_W-1:0] in_ram_ctrl,
  input  logic              in_l,
  input  logic              in_rf_le,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rb,
  output logic [DATA_W-1:0] out_alu,
  output logic [RD_W-1:0]   out_rd,
  output logic [RAMC_W-1:0] out_ram_ctrl,
  output logic              out_l,
  output logic              out_rf_le
);

  typedef struct packed {
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
    logic [RAMC_W-1:0] ram_ctrl;
    logic              l;
    logic              rf_le;
  } payload_t;

  localparam int PW = payload_w(DATA_W, RD_W, RAMC_W);

  payload_t in_pl, main_pl, main_d, skid_pl;
  logic     main_valid, skid_valid;
  logic     accept, drain, advance, main_load, main_clear;

  assign in_pl   = '{rb: in_rb, alu: in_alu, rd: in_rd, ram_ctrl: in_ram_ctrl,
                     l: in_l, rf_le: in_rf_le};
  assign accept  = in_valid & in_ready & ~flush;
  assign drain   = main_valid & out_ready;
  assign advance = drain | ~main_valid;

  // A waiting skid entry always moves up before any new input, keeping order.
  assign main_d     = skid_valid ? skid_pl : in_pl;
  assign main_load  = ~flush & advance & (skid_valid | accept);
  assign main_clear = flush | (advance & ~skid_valid & ~accept);

  pipe_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (Reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_pl),
    .valid (main_valid)
  );

  if (SKID_EN) begin : g_skid
    logic skid_load, skid_clear;

    assign skid_load  = accept & main_valid & ~drain;
    assign skid_clear = flush | (skid_valid & advance);
    // in_ready comes only from registered state, breaking the out_ready path.
    assign in_ready   = ~skid_valid & ~Reset;

    pipe_slot #(.W(PW)) u_skid (
      .clk   (clk),
      .rst   (Reset),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_pl),
      .q     (skid_pl),
      .valid (skid_valid)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_pl    = '0;
    assign in_ready   = (out_ready | ~main_valid) & ~Reset;
  end

  assign out_valid    = main_valid;
  assign out_rb       = main_pl.rb;
  assign out_alu      = main_pl.alu;
  assign out_rd       = main_pl.rd;
  assign out_ram_ctrl = main_valid ? main_pl.ram_ctrl : RAMC_W'(RAMC_NONE);
  assign out_l        = main_pl.l & main_valid;
  assign out_rf_le    = main_pl.rf_le & main_valid;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_stage.sv
`default_nettype none
// ==========================================================================
// tb_ex_mem_skid_stage : bench for both skid and no-skid builds of the stage
// Revision 1.0
// ==========================================================================
module tb_ex_mem_skid_stage;

  typedef struct packed {
    logic [31:0] rb;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [3:0]  rc;
    logic        l;
    logic        rf;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, in_l, in_rf_le;
  logic [31:0] in_rb, in_alu;
  logic [4:0]  in_rd;
  logic [3:0]  in_ram_ctrl;

  logic        in_ready     [2];
  logic        out_valid    [2];
  logic        out_l        [2];
  logic        out_rf_le    [2];
  logic [31:0] out_rb       [2];
  logic [31:0] out_alu      [2];
  logic [4:0]  out_rd       [2];
  logic [3:0]  out_ram_ctrl [2];

  int checks = 0;
  int errors = 0;
  bit model_ok = 1'b0;
  bit seen_dead = 1'b0;

  // Reference: instance k is an in-order queue of depth 2 (skid) or 1 (no skid)
  pl_t mbuf  [2][2];
  int  mcnt  [2];
  pl_t mlast [2];

  always #5 clk = ~clk;

  ex_mem_skid_stage #(.DATA_W(32), .RD_W(5), .RAMC_W(4), .SKID_EN(1'b1)) u_dut_skid (
    .clk(clk), .Reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_rb(in_rb), .in_alu(in_alu), .in_rd(in_rd), .in_ram_ctrl(in_ram_ctrl),
    .in_l(in_l), .in_rf_le(in_rf_le), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_rb(out_rb[0]), .out_alu(out_alu[0]), .out_rd(out_rd[0]),
    .out_ram_ctrl(out_ram_ctrl[0]), .out_l(out_l[0]), .out_rf_le(out_rf_le[0])
  );

  ex_mem_skid_stage #(.DATA_W(32), .RD_W(5), .RAMC_W(4), .SKID_EN(1'b0)) u_dut_noskid (
    .clk(clk), .Reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_rb(in_rb), .in_alu(in_alu), .in_rd(in_rd), .in_ram_ctrl(in_ram_ctrl),
    .in_l(in_l), .in_rf_le(in_rf_le), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_rb(out_rb[1]), .out_alu(out_alu[1]), .out_rd(out_rd[1]),
    .out_ram_ctrl(out_ram_ctrl[1]), .out_l(out_l[1]), .out_rf_le(out_rf_le[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int k);
    if (rst) return 1'b0;
    if (k == 0) return mcnt[0] < 2;
    return (mcnt[1] == 0) || out_ready;
  endfunction

  always @(posedge clk) begin
    pl_t cur;
    bit  rdy, acc, drn;
    cur = '{rb: in_rb, alu: in_alu, rd: in_rd, rc: in_ram_ctrl, l: in_l, rf: in_rf_le};
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mcnt[k]  = 0;
        mlast[k] = '0;
      end else if (flush) begin
        mcnt[k] = 0;
      end else begin
        rdy = m_ready(k);
        acc = in_valid && rdy;
        drn = (mcnt[k] > 0) && out_ready;
        if (drn) begin
          mbuf[k][0] = mbuf[k][1];
          mcnt[k]--;
        end
        if (acc) begin
          mbuf[k][mcnt[k]] = cur;
          mcnt[k]++;
        end
      end
      if (mcnt[k] > 0) mlast[k] = mbuf[k][0];
    end
    if (rst) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        pl_t e;
        bit  v;
        v = mcnt[k] > 0;
        e = v ? mbuf[k][0] : mlast[k];
        chk($sformatf("sb%0d_valid", k), 32'(out_valid[k]), 32'(v));
        chk($sformatf("sb%0d_in_ready", k), 32'(in_ready[k]), 32'(m_ready(k)));
        chk($sformatf("sb%0d_alu", k), out_alu[k], e.alu);
        chk($sformatf("sb%0d_rb", k), out_rb[k], e.rb);
        chk($sformatf("sb%0d_rd", k), 32'(out_rd[k]), 32'(e.rd));
        chk($sformatf("sb%0d_ram_ctrl", k), 32'(out_ram_ctrl[k]), v ? 32'(e.rc) : 32'd0);
        chk($sformatf("sb%0d_l", k), 32'(out_l[k]), 32'(e.l & v));
        chk($sformatf("sb%0d_rf_le", k), 32'(out_rf_le[k]), 32'(e.rf & v));
        if (out_valid[k] && out_alu[k] == 32'hDEAD) seen_dead = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] alu);
    in_valid    = v;
    in_alu      = alu;
    in_rb       = ~alu;
    in_rd       = alu[4:0];
    in_ram_ctrl = 4'b1010;
    in_l        = 1'b1;
    in_rf_le    = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h55);
    cyc();
    cyc();
    #1;
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_out_rf_le", 32'(out_rf_le[0]), 32'd0);
    chk("rst_out_ram_ctrl", 32'(out_ram_ctrl[0]), 32'd0);
    chk("rst_out_alu", out_alu[0], 32'd0);
    chk("rst_in_ready_skid", 32'(in_ready[0]), 32'd0);
    chk("rst_in_ready_noskid", 32'(in_ready[1]), 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    chk("post_rst_in_ready", 32'(in_ready[0]), 32'd1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(i));
      cyc();
      chk("stream_alu_skid", out_alu[0], 32'h100 + 32'(i));
      chk("stream_alu_noskid", out_alu[1], 32'h100 + 32'(i));
      chk("stream_valid", 32'(out_valid[0]), 32'd1);
    end
    drive(1'b0, 32'h0);
    cyc();
    chk("stream_end_valid", 32'(out_valid[0]), 32'd0);

    // Stall with one entry absorbed into the skid slot
    drive(1'b1, 32'hA);
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 32'hB);
    #1;
    chk("noskid_in_ready_stall", 32'(in_ready[1]), 32'd0);
    chk("skid_in_ready_prestall", 32'(in_ready[0]), 32'd1);
    cyc();
    chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
    chk("stall_alu", out_alu[0], 32'hA);
    drive(1'b1, 32'hC);
    cyc();
    chk("stall_hold_alu", out_alu[0], 32'hA);
    out_ready = 1'b1;
    cyc();
    chk("release_alu_b", out_alu[0], 32'hB);
    cyc();
    chk("release_alu_c", out_alu[0], 32'hC);
    drive(1'b0, 32'h0);
    cyc();
    chk("release_end_valid", 32'(out_valid[0]), 32'd0);

    // Flush while stalled with the skid slot full
    drive(1'b1, 32'h20);
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 32'h21);
    cyc();
    drive(1'b0, 32'h0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid[0]), 32'd0);
    chk("flush_rf_le", 32'(out_rf_le[0]), 32'd0);
    chk("flush_in_ready", 32'(in_ready[0]), 32'd1);
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("flush_no_reappear", 32'(out_valid[0]), 32'd0);

    // Flush drops the entry presented in the same cycle
    flush = 1'b1;
    drive(1'b1, 32'hDEAD);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    chk("flush_in_valid", 32'(out_valid[0]), 32'd0);
    cyc();
    cyc();

    // Random valid/ready/flush traffic with one reset pulse mid-run
    for (int n = 0; n < 400; n++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_alu      = {1'b1, 31'($urandom)};
      in_rb       = $urandom;
      in_rd       = 5'($urandom);
      in_ram_ctrl = 4'($urandom);
      in_l        = 1'($urandom);
      in_rf_le    = 1'($urandom);
      out_ready   = (n < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      rst         = (n == 150);
      cyc();
    end
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0);
    cyc();
    cyc();

    chk("dead_never_seen", 32'(seen_dead), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
